aes_128_dec: RTL and testbench
==============================

Name: aes_128_dec

Overview:
Iterative AES-128 inverse cipher (FIPS-197 Sec. 5.3): converts a 128-bit ciphertext to plaintext, executing one transformation per clock. It is the decrypt counterpart of the AES_128 encryption core. It shares that core's key_expansion block, fetching round keys by index through a combinational lookup. A start/done handshake drives it.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported. Any other value is a synthesis-time error.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request to decrypt; sampled only in IDLE
ciphertext  input  128  input block, byte 0 = bits [127:120]; sampled in the start cycle
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; plaintext valid in that cycle
plaintext  output  128  result register; holds until the next completion
rk_round  output  4  round-key index requested (0..10)
round_key  input  128  round key for rk_round; must be valid combinationally in the same cycle

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, plaintext=0, rk_round=10, round counter=10, internal state register=0. Reset overrides everything, including start in the same cycle and any operation in flight; a partial result is never exposed.
- FSM states: IDLE, ADD_KEY, INV_SHIFT, INV_SUB, INV_MIX, DONE.
- IDLE: if start=1, load ciphertext into the state register, set round=10, go to ADD_KEY. Otherwise stay.
- ADD_KEY: state ^= round_key, with rk_round=round. Next state:
  - round=0: go to DONE and register the result into plaintext.
  - round=10: go to INV_SHIFT and decrement round.
  - otherwise: go to INV_MIX.
- INV_MIX: apply InvMixColumns to all 4 columns. Use GF(2^8) multiply by 0e/0b/0d/09 built from xtime, reduction polynomial 0x11b. Decrement round, then go to INV_SHIFT.
- INV_SHIFT: row r rotates right by r bytes, r=0..3. Go to INV_SUB.
- INV_SUB: apply the inverse S-box to all 16 bytes. Go to ADD_KEY.
- Resulting operation order:
  - ARK(10);
  - rounds 9..1: InvShift, InvSub, ARK(r), InvMix;
  - final: InvShift, InvSub, ARK(0).
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Latency: start accepted in cycle T gives done=1 in cycle T+41 (40 transformation cycles). Back-to-back operation: the earliest next accepted start is T+42.
- start while busy=1 or in DONE: ignored, with no effect on the result. start held high continuously gives one decryption per 42 cycles.
- ciphertext changes after the start cycle have no effect.
- rk_round equals the round counter in every cycle. It is meaningful only during ADD_KEY and holds its value elsewhere.
- busy and done are never high together.

Decomposition:
- Shared package aes_pkg holds:
  - FSM state encoding localparams (3-bit);
  - NR and the round-key index width;
  - functions xtime, gf_mul_09/0b/0d/0e, and inv_mix_column (32-bit in, 32-bit out);
  - the byte/word/state indexing convention shared with the encryption core.
- One sub-module aes_inv_sbox: 8-bit in, 8-bit out, combinational, standard FIPS-197 inverse table. Instantiate 16 times.
- InvShiftRows is pure wiring inside the top.

Test Plan:
1. FIPS-197 C.1.
   - Stimulus: key 000102030405060708090a0b0c0d0e0f, expanded by a bench round-key model; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
   - Required response: plaintext 00112233445566778899aabbccddeeff, with done exactly 41 cycles after start.
2. FIPS-197 App. B.
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c; ciphertext 3925841d02dc09fbdc118597196a0b32.
   - Required response: plaintext 3243f6a8885a308d313198a2e0370734. rk_round sequence sampled in ADD_KEY cycles must be 10,9,...,0.
3. Busy protection.
   - Stimulus: run vector 1, then pulse start with a different ciphertext at T+5 and again in the DONE cycle.
   - Required response: both pulses ignored; result still 00112233445566778899aabbccddeeff; a single done pulse.
4. Reset mid-operation.
   - Stimulus: assert rst at T+20 for 1 cycle, then start vector 2.
   - Required response: busy=0, done=0, plaintext=0 right after reset; the new run produces 3243f6a8...0734 at 41 cycles.
5. Back-to-back.
   - Stimulus: hold start=1 with vector 1 and then vector 2 presented.
   - Required response: done at T+41 and T+83 with the correct plaintexts; plaintext holds its value between the two done pulses.
6. Round trip.
   - Stimulus: 100 random key/plaintext pairs, with ciphertext generated by the AES_128 encryption core.
   - Required response: decrypted output equals the original plaintext in every case.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: definitions shared by the AES-128 cores.
//   - FSM state encoding of the iterative inverse cipher (3 bits)
//   - round count and the round-key index width
//   - GF(2^8) helpers (xtime, multiply by 09/0b/0d/0e) and inv_mix_column
// Block layout, identical to the encryption core: byte i of a 128-bit block
// sits at bits [127-8*i -: 8]. Bytes are column-major, so byte i is
// row i%4 of column i/4, and column c occupies bits [127-32*c -: 32].
package aes_pkg;

  localparam int AES128_NR = 10;
  localparam int RK_IDX_W  = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADD_KEY   = 3'd1;
  localparam logic [2:0] ST_INV_SHIFT = 3'd2;
  localparam logic [2:0] ST_INV_SUB   = 3'd3;
  localparam logic [2:0] ST_INV_MIX   = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One column of InvMixColumns; row 0 is the most significant byte.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3),
            gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3),
            gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3),
            gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box (FIPS-197 table).
//   val : input byte
//   inv : InvSubBytes(val)
module aes_inv_sbox (
  input  logic [7:0] val,
  output logic [7:0] inv
);

  // Entry for byte v is at bits [8*(255-v) +: 8], i.e. row 0 is the top word.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] bit_idx;

  // 8*(255-v) == {~v, 3'b000}
  assign bit_idx = {~val, 3'b000};
  assign inv     = INV_SBOX[bit_idx +: 8];

endmodule

// File: rtl/aes_128_dec.sv
// aes_128_dec: iterative AES-128 inverse cipher, one transformation per clock.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : decrypt request, accepted only in IDLE
//   ciphertext : input block, captured in the accepting cycle
//   busy       : operation in progress (cycle after accept up to DONE)
//   done       : one-cycle pulse, plaintext valid in that cycle
//   plaintext  : result register, held until the next completion
//   rk_round   : round-key index presented to the key-expansion lookup
//   round_key  : key for rk_round, valid combinationally in the same cycle
//   fsm_state  : current FSM state (debug observation)
// Handshake: start is a request sampled at a rising edge while IDLE; the
// matching completion is the single cycle in which done is high. There is
// no backpressure: start in any other state is dropped.
// Order: ARK(10); rounds 9..1: InvShift, InvSub, ARK(r), InvMix;
// final: InvShift, InvSub, ARK(0). 40 working cycles, done on the 41st.
module aes_128_dec
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [127:0]        ciphertext,
  output logic                busy,
  output logic                done,
  output logic [127:0]        plaintext,
  output logic [RK_IDX_W-1:0] rk_round,
  input  logic [127:0]        round_key,
  output logic [2:0]          fsm_state
);

  if (NR != AES128_NR) begin : g_nr_check
    $error("aes_128_dec: only NR = 10 (AES-128) is supported");
  end

  localparam logic [RK_IDX_W-1:0] FIRST_ROUND = RK_IDX_W'(NR);

  logic [2:0]          state_q, state_d;
  logic [127:0]        blk_q;
  logic [RK_IDX_W-1:0] round_q;
  logic [127:0]        shift_out, sub_out, mix_out, ark_out;

  assign ark_out   = blk_q ^ round_key;
  assign rk_round  = round_q;
  assign fsm_state = state_q;

  // Row r rotates right by r: output (r,c) takes input (r,(c-r) mod 4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shift_out[127-8*(4*c+r) -: 8] =
        blk_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      aes_inv_sbox u_inv_sbox (
        .val (blk_q[127-8*(4*c+r) -: 8]),
        .inv (sub_out[127-8*(4*c+r) -: 8])
      );
    end
    assign mix_out[127-32*c -: 32] = inv_mix_column(blk_q[127-32*c -: 32]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_ADD_KEY;
      ST_ADD_KEY: begin
        // The first ARK has no InvMix after it; the last one ends the run.
        if (round_q == '0)               state_d = ST_DONE;
        else if (round_q == FIRST_ROUND) state_d = ST_INV_SHIFT;
        else                             state_d = ST_INV_MIX;
      end
      ST_INV_MIX:   state_d = ST_INV_SHIFT;
      ST_INV_SHIFT: state_d = ST_INV_SUB;
      ST_INV_SUB:   state_d = ST_ADD_KEY;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_ADD_KEY, ST_INV_SHIFT, ST_INV_SUB, ST_INV_MIX: busy = 1'b1;
      ST_DONE:                                          done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: block register, round counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q     <= '0;
      round_q   <= FIRST_ROUND;
      plaintext <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            blk_q   <= ciphertext;
            round_q <= FIRST_ROUND;
          end
        end
        ST_ADD_KEY: begin
          blk_q <= ark_out;
          // Round 10 has no InvMix, so it decrements here instead.
          if (round_q == FIRST_ROUND) round_q <= round_q - 4'd1;
          if (round_q == '0)          plaintext <= ark_out;
        end
        ST_INV_MIX: begin
          blk_q   <= mix_out;
          round_q <= round_q - 4'd1;
        end
        ST_INV_SHIFT: blk_q <= shift_out;
        ST_INV_SUB:   blk_q <= sub_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_dec.sv
// tb_aes_128_dec: self-checking bench for aes_128_dec. A byte-level AES-128
// forward model (S-box derived from GF(2^8) inverses, key expansion,
// encryption) supplies round keys and ciphertexts; a monitor pops expected
// plaintexts and start cycles from queues on every done pulse.
module tb_aes_128_dec;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] ciphertext;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;
  logic [3:0]   rk_round;
  logic [127:0] round_key;
  logic [2:0]   fsm_state;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  aes_128_dec #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext),
    .rk_round   (rk_round),
    .round_key  (round_key),
    .fsm_state  (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk_tab [11];

  assign round_key = (rk_round <= 4'd10) ? rk_tab[rk_round] : '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int v = 0; v < 256; v++) begin
      b = 8'h00;
      for (int u = 1; u < 256; u++)
        if (gmul(8'(v), 8'(u)) == 8'h01) b = 8'(u);
      sbox[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]}
            ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher on a 16-byte array using the current rk_tab.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] res;
    rk = rk_tab[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      rk = rk_tab[r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [127:0] exp_q [$];
  int           lat_q [$];
  logic [127:0] mon_exp;
  int           mon_t0;

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_with_done busy=%0b required 0", busy);
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d plaintext=%h", cyc, plaintext);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_t0  = lat_q.pop_front();
        checks++;
        if (plaintext !== mon_exp) begin
          errors++;
          $display("FAIL plaintext got=%h required=%h", plaintext, mon_exp);
        end
        checks++;
        if (cyc - mon_t0 != 41) begin
          errors++;
          $display("FAIL latency got=%0d required=41", cyc - mon_t0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the start was accepted.
  task automatic issue(input logic [127:0] ct, input logic [127:0] pt);
    int n;
    n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%0b done=%0b required 0 0", busy, done);
    end
    start      = 1'b1;
    ciphertext = ct;
    exp_q.push_back(pt);
    lat_q.push_back(cyc);
    @(negedge clk);
    start      = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got=%0b required=1", busy);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [127:0] got,
                           input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, n, exp_r;
    logic hold_bad;
    logic [127:0] key, pt;

    rst = 1'b1;
    start = 1'b1;   // start during reset must be ignored
    ciphertext = CT1;
    build_sbox();
    expand_key(KEY1);
    repeat (3) @(negedge clk);
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_done", 128'(done), 128'(0));
    check_val("rst_plaintext", plaintext, 128'(0));
    check_val("rst_rk_round", 128'(rk_round), 128'(10));
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 1: FIPS-197 C.1
    issue(CT1, PT1);
    drain();

    // 2: FIPS-197 App. B with rk_round sampled at the ARK cycles
    expand_key(KEY2);
    issue(CT2, PT2);
    for (int k = 1; k <= 40; k++) begin
      exp_r = -1;
      if (k == 1) exp_r = 10;
      else if (k % 4 == 0) exp_r = 9 - (k - 4) / 4;
      if (exp_r >= 0) check_val("rk_round_seq", 128'(rk_round), 128'(exp_r));
      @(negedge clk);
    end
    drain();

    // 3: start pulses while busy and in DONE are ignored
    expand_key(KEY1);
    d0 = done_cnt;
    issue(CT1, PT1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    ciphertext = CT2;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("done_seen", 128'(done), 128'(1));
    start = 1'b1;
    ciphertext = CT2;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check_val("single_done", 128'(done_cnt - d0), 128'(1));
    check_val("protect_hold", plaintext, PT1);

    // 4: reset mid-operation
    issue(CT1, PT1);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    check_val("midrst_busy", 128'(busy), 128'(0));
    check_val("midrst_done", 128'(done), 128'(0));
    check_val("midrst_plaintext", plaintext, 128'(0));
    expand_key(KEY2);
    issue(CT2, PT2);
    drain();

    // 5: back-to-back with start held high
    expand_key(KEY1);
    start = 1'b1;
    ciphertext = CT1;
    exp_q.push_back(PT1);
    lat_q.push_back(cyc);
    @(negedge clk);
    ciphertext = CT2;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    expand_key(KEY2);
    exp_q.push_back(PT2);
    lat_q.push_back(cyc + 1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    hold_bad = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      if (plaintext !== PT1) hold_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check_val("b2b_hold", 128'(hold_bad), 128'(0));
    drain();

    // 6: random round trips through the forward model
    for (int i = 0; i < 100; i++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i == 0) pt = '0;
      if (i == 1) pt = '1;
      expand_key(key);
      issue(encrypt(pt), pt);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
